// File: rtl/clock_divider_bank.sv
// N-stage binary clock divider bank with per-stage phase ticks and a selectable processor clock.
// Define CLKDIV_RUNTIME_SEL_EN to enable run-time changes of the processor clock ratio.
module clock_divider_bank #(
  parameter int STAGES       = 3,
  parameter int PROC_DEFAULT = 2,
  parameter int SEL_W        = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              sel_req,
  input  logic [SEL_W-1:0]  sel,
  output logic [STAGES-1:0] div_clk,
  output logic [STAGES-1:0] tick,
  output logic              proc_clk,
  output logic              sel_ack
);

  logic [STAGES-1:0] cnt_q, cnt_d;
  logic [STAGES-1:0] tick_q, tick_d;
  logic              proc_clk_q, proc_clk_d;
  logic              sel_ack_q, sel_ack_d;
  logic [SEL_W-1:0]  active_sel_d;
  logic              proc_bit;

  always_comb begin
    cnt_d = cnt_q;
    if (run) cnt_d = cnt_q + STAGES'(1);
  end

  // A stage ticks when the next count has its low bits equal to 1 followed by zeros.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_tick
    localparam int PAT  = 1 << gi;
    localparam int MASK = (2 << gi) - 1;
    assign tick_d[gi] = run && ((int'(cnt_d) & MASK) == PAT);
  end

`ifdef CLKDIV_RUNTIME_SEL_EN
  logic [SEL_W-1:0] active_sel_q;
  logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
  logic             pend_vld_q, pend_vld_d;
  logic [SEL_W-1:0] sel_clamped;
  logic             wrap;

  assign wrap = run && (cnt_q == {STAGES{1'b1}});

  always_comb begin
    sel_clamped = sel;
    if (sel == '0)
      sel_clamped = SEL_W'(1);
    else if (sel > SEL_W'(STAGES))
      sel_clamped = SEL_W'(STAGES);
  end

  // A request arriving on the wrap edge itself takes effect immediately.
  always_comb begin
    active_sel_d = active_sel_q;
    pend_sel_d   = pend_sel_q;
    pend_vld_d   = pend_vld_q;
    sel_ack_d    = 1'b0;
    if (wrap && sel_req) begin
      active_sel_d = sel_clamped;
      pend_vld_d   = 1'b0;
      sel_ack_d    = 1'b1;
    end else if (wrap && pend_vld_q) begin
      active_sel_d = pend_sel_q;
      pend_vld_d   = 1'b0;
      sel_ack_d    = 1'b1;
    end else if (sel_req) begin
      pend_sel_d = sel_clamped;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_sel_q <= SEL_W'(PROC_DEFAULT);
      pend_sel_q   <= '0;
      pend_vld_q   <= 1'b0;
    end else begin
      active_sel_q <= active_sel_d;
      pend_sel_q   <= pend_sel_d;
      pend_vld_q   <= pend_vld_d;
    end
  end
`else
  logic unused_sel;
  assign unused_sel   = ^{sel_req, sel};
  assign active_sel_d = SEL_W'(PROC_DEFAULT);
  assign sel_ack_d    = 1'b0;
`endif

  // proc_clk tracks the next counter bit of the stage that will be active after this edge.
  always_comb begin
    proc_bit = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if (active_sel_d == SEL_W'(i + 1)) proc_bit = cnt_d[i];
    end
    proc_clk_d = run ? proc_bit : proc_clk_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      tick_q     <= '0;
      proc_clk_q <= 1'b0;
      sel_ack_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      proc_clk_q <= proc_clk_d;
      sel_ack_q  <= sel_ack_d;
    end
  end

  assign div_clk  = cnt_q;
  assign tick     = tick_q;
  assign proc_clk = proc_clk_q;
  assign sel_ack  = sel_ack_q;

endmodule
